// File: rtl/cpu_pipeline_ctrl.sv
// rtl/cpu_pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Merges hazard, branch and memory-wait causes; sequences debug halt/drain/resume.
module cpu_pipeline_ctrl #(
  parameter int CNT_W        = 32,
  parameter int TIMEOUT      = 255,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hdu_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             stall_mem,
  output logic             flush_decode,
  output logic             flush_execute,
  output logic             flush_wb,
  output logic             pc_redirect,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int DRN_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               halted_q, halted_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;

  logic mstall;
  logic active_mstall;
  logic br_fire;

  assign mstall        = dmem_req & ~dmem_ready;
  assign active_mstall = mstall && (state_q != HALTED);

  // Only the highest-priority active cause drives the controls.
  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_execute = 1'b0;
    stall_mem     = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    flush_wb      = 1'b0;
    pc_redirect   = 1'b0;
    br_fire       = 1'b0;
    if (state_q == HALTED) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_mem     = 1'b1;
    end else begin
      if (mstall) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_execute = 1'b1;
        stall_mem     = 1'b1;
        flush_wb      = 1'b1;
      end else if (branch_taken) begin
        flush_decode  = 1'b1;
        flush_execute = 1'b1;
        pc_redirect   = 1'b1;
        br_fire       = 1'b1;
      end else if (hdu_stall) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        flush_execute = 1'b1;
      end else if (!imem_ready) begin
        stall_fetch   = 1'b1;
        flush_decode  = 1'b1;
      end
      // Drain stops new fetches while older instructions retire.
      if (state_q == DRAIN) begin
        stall_fetch  = 1'b1;
        flush_decode = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d     = DRAIN;
          drain_cnt_d = DRN_W'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (!mstall) begin
          drain_cnt_d = drain_cnt_q - DRN_W'(1);
        end
      end
      HALTED: begin
        if (resume) begin
          state_d  = RUN;
          halted_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase

    if (active_mstall)
      wait_cnt_d = (wait_cnt_q == WAIT_W'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    else
      wait_cnt_d = '0;
    mem_timeout_d = mem_timeout_q | (active_mstall && (wait_cnt_q == WAIT_W'(TIMEOUT - 1)));

    stall_count_d = stall_count_q;
    if (stall_fetch && (state_q != HALTED) && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
    flush_count_d = flush_count_q;
    if (br_fire && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      halted_q      <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// tb/tb_cpu_pipeline_ctrl.sv - directed scoreboard bench for cpu_pipeline_ctrl
module tb_cpu_pipeline_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic hdu_stall, branch_taken, dmem_req, dmem_ready, imem_ready, halt_req, resume;
  logic stall_fetch, stall_decode, stall_execute, stall_mem;
  logic flush_decode, flush_execute, flush_wb, pc_redirect, halted, mem_timeout;
  logic [31:0] stall_count, flush_count;
  logic [9:0] obs;

  localparam logic [9:0] SF = 10'b1000000000;
  localparam logic [9:0] SD = 10'b0100000000;
  localparam logic [9:0] SE = 10'b0010000000;
  localparam logic [9:0] SM = 10'b0001000000;
  localparam logic [9:0] FD = 10'b0000100000;
  localparam logic [9:0] FE = 10'b0000010000;
  localparam logic [9:0] FW = 10'b0000001000;
  localparam logic [9:0] PR = 10'b0000000100;
  localparam logic [9:0] HL = 10'b0000000010;
  localparam logic [9:0] MT = 10'b0000000001;
  localparam logic [9:0] MS = SF | SD | SE | SM | FW;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int tests = 0;
  int fails = 0;

  cpu_pipeline_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .hdu_stall(hdu_stall), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .halt_req(halt_req), .resume(resume),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .stall_execute(stall_execute), .stall_mem(stall_mem),
    .flush_decode(flush_decode), .flush_execute(flush_execute),
    .flush_wb(flush_wb), .pc_redirect(pc_redirect),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign obs = {stall_fetch, stall_decode, stall_execute, stall_mem,
                flush_decode, flush_execute, flush_wb, pc_redirect, halted, mem_timeout};

  task automatic drive(input logic hdu, br, dreq, drdy, irdy, hreq, res);
    hdu_stall = hdu; branch_taken = br; dmem_req = dreq; dmem_ready = drdy;
    imem_ready = irdy; halt_req = hreq; resume = res;
  endtask

  task automatic step(input logic hdu, br, dreq, drdy, irdy, hreq, res,
                      input logic [9:0] exp, input string tag);
    sb_t e;
    drive(hdu, br, dreq, drdy, irdy, hreq, res);
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    tests++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chk_obs(input string tag, input logic [9:0] e);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_obs("reset_outputs", 10'b0);
    chk_cnt("reset_stall_count", stall_count, 32'd0);
    chk_cnt("reset_flush_count", flush_count, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    step(0, 0, 0, 0, 1, 0, 0, 10'b0, "idle");
    step(1, 0, 0, 0, 1, 0, 0, SF | SD | FE, "load_use");
    chk_cnt("load_use_stall_count", stall_count, 32'd1);
    step(1, 1, 0, 0, 1, 0, 0, FD | FE | PR, "branch_over_hdu");
    chk_cnt("branch_flush_count", flush_count, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, SF | FD, "imem_wait");

    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 0, 0, MS, "mstall_over_branch");
    step(0, 1, 1, 1, 1, 0, 0, FD | FE | PR, "branch_after_mem");
    chk_cnt("mem_stall_count", stall_count, 32'd5);
    chk_cnt("mem_flush_count", flush_count, 32'd2);

    step(0, 0, 0, 0, 1, 1, 0, 10'b0, "halt_req_run");
    step(0, 0, 0, 0, 1, 0, 0, SF | FD, "drain_1");
    step(0, 0, 1, 0, 1, 0, 0, MS | FD, "drain_mstall");
    step(0, 1, 0, 0, 1, 0, 0, SF | FD | FE | PR, "drain_branch");
    step(0, 0, 0, 0, 1, 0, 0, SF | FD, "drain_4");
    step(0, 0, 0, 0, 1, 0, 0, SF | FD, "drain_5");
    step(0, 0, 0, 0, 1, 0, 0, SF | FD, "drain_6");
    step(1, 1, 0, 0, 0, 1, 0, SF | SD | SE | SM | HL, "halted_ignore");
    step(0, 0, 0, 0, 1, 0, 1, SF | SD | SE | SM | HL, "resume_sampled");
    step(0, 0, 0, 0, 1, 0, 0, 10'b0, "run_after_resume");
    chk_cnt("halt_stall_count", stall_count, 32'd11);
    chk_cnt("halt_flush_count", flush_count, 32'd3);

    for (int i = 0; i < 254; i++) step(0, 0, 1, 0, 1, 0, 0, MS, "tmo_254");
    step(0, 0, 1, 1, 1, 0, 0, 10'b0, "tmo_ready");
    step(0, 0, 0, 0, 1, 0, 0, 10'b0, "tmo_not_set");
    for (int i = 0; i < 255; i++) step(0, 0, 1, 0, 1, 0, 0, MS, "tmo_255");
    step(0, 0, 0, 0, 1, 0, 0, MT, "tmo_set");
    step(0, 0, 0, 0, 1, 0, 0, MT, "tmo_sticky");
    chk_cnt("tmo_stall_count", stall_count, 32'd520);

    force dut.stall_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_count_q;
    step(1, 0, 0, 0, 1, 0, 0, SF | SD | FE | MT, "sat_load_use");
    chk_cnt("sat_stall_count", stall_count, 32'hFFFF_FFFF);
    chk_cnt("sat_flush_count", flush_count, 32'd3);

    step(0, 0, 0, 0, 1, 1, 0, MT, "halt_req_2");
    step(0, 0, 0, 0, 1, 0, 0, SF | FD | MT, "drain_before_reset");
    reset_n = 1'b0;
    #1;
    chk_obs("reset_mid_drain_outputs", 10'b0);
    chk_cnt("reset_mid_drain_stall_count", stall_count, 32'd0);
    chk_cnt("reset_mid_drain_flush_count", flush_count, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(0, 0, 0, 0, 1, 0, 0, 10'b0, "run_after_reset");
    step(0, 0, 0, 0, 1, 0, 0, 10'b0, "idle_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_pipeline_ctrl.md
# cpu_pipeline_ctrl

Central stall/flush sequencer for the 5-stage CPU pipeline (F, D, E, M, WB). It merges the hazard-detection unit's load-use stall, the branch resolution from execute, and the instruction/data memory wait signals into one consistent set of per-stage stall and bubble controls. It also sequences a debug halt/drain/resume, flags stuck data-memory accesses, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters
- TIMEOUT, 255, number of consecutive data-memory wait cycles that sets `mem_timeout`
- DRAIN_CYCLES, 4, non-frozen cycles spent in DRAIN before reaching HALTED

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- hdu_stall  in  1  load-use stall from the hazard detection unit
- branch_taken  in  1  branch/jump resolved taken in E this cycle
- dmem_req  in  1  M stage has an access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- imem_ready  in  1  instruction memory returns the fetch this cycle
- halt_req  in  1  debug halt request, level
- resume  in  1  leave HALTED, pulse
- stall_fetch / stall_decode / stall_execute / stall_mem  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register
- flush_decode  out  1  load a bubble into IF/ID
- flush_execute  out  1  load a bubble into ID/EX
- flush_wb  out  1  load a bubble into MEM/WB
- pc_redirect  out  1  PC mux selects the branch target
- halted  out  1  pipeline drained and frozen
- mem_timeout  out  1  sticky stuck-memory error
- stall_count  out  CNT_W  cycles with `stall_fetch`=1 outside HALTED, saturating
- flush_count  out  CNT_W  branch flushes performed, saturating

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Define mstall = `dmem_req` & ~`dmem_ready`. Control outputs are combinational from state and inputs. Priority is highest first, and only the highest active cause acts.
  1. mstall (RUN or DRAIN):
     - Assert stall_fetch, stall_decode, stall_execute, stall_mem and flush_wb.
     - `branch_taken` and `hdu_stall` are ignored; upstream holds them.
  2. `branch_taken`:
     - Assert flush_decode, flush_execute and pc_redirect.
     - `hdu_stall` is ignored.
  3. `hdu_stall`:
     - Assert stall_fetch and stall_decode.
     - Assert flush_execute.
  4. ~`imem_ready`:
     - Assert stall_fetch.
     - Assert flush_decode.
- DRAIN behaviour:
  - stall_fetch=1 and flush_decode=1 every cycle, in addition to any cause above.
  - pc_redirect still honoured for a taken branch; the target PC is latched and fetched after resume.
  - drain_cnt loads DRAIN_CYCLES on entry and decrements on each cycle with mstall=0. DRAIN→HALTED when it reaches 0.
- HALTED behaviour:
  - All four stalls = 1, all flushes = 0, pc_redirect = 0.
  - halted = 1. Inputs are ignored except `resume`.
- Transitions:
  - RUN→DRAIN when `halt_req`=1.
  - HALTED→RUN when `resume`=1.
  - `halt_req` deasserting during DRAIN does not abort the drain.
  - `resume` outside HALTED is ignored.
- Timeout:
  - wait_cnt increments on every mstall cycle and clears on any cycle with mstall=0.
  - `mem_timeout` sets when wait_cnt reaches TIMEOUT and clears only on reset.
- Counters:
  - Increment by 1 and hold at all-ones.
  - flush_count increments on every cycle where rule 2 fires.

## Timing
- Reset values:
  - State RUN; drain_cnt, wait_cnt, stall_count and flush_count are 0.
  - mem_timeout=0 and halted=0.
  - With idle inputs (dmem_req=0, imem_ready=1, others 0), every stall, flush and redirect output is 0.
- Control outputs have zero latency from the inputs. State, counters and mem_timeout update on the rising clk edge.
- halted rises on the first cycle after drain_cnt reaches 0. It falls on the cycle after `resume` is sampled.
- mem_timeout is visible on the cycle after the TIMEOUT-th consecutive mstall cycle.
- Asserting reset_n low mid-DRAIN or mid-stall returns everything to its reset values immediately; no pending redirect survives reset.

## Test plan
- Load-use: hdu_stall=1 for 1 cycle → stall_fetch=stall_decode=flush_execute=1 that cycle; stall_count=1.
- Branch with concurrent hdu_stall=1 → flush_decode=flush_execute=pc_redirect=1, stall_decode=0; flush_count=1.
- dmem_req=1, dmem_ready=0 for 3 cycles while branch_taken=1 → 3 cycles with all four stalls and flush_wb=1 and no redirect; on the 4th cycle (dmem_ready=1) the redirect fires.
- Halt with DRAIN_CYCLES=4, including one mstall cycle during DRAIN → halted rises exactly 6 cycles after halt_req is sampled; one resume pulse → RUN, all outputs 0.
- TIMEOUT=255 with 255 consecutive mstall cycles → mem_timeout=1 on the next cycle and stays set after mstall ends. With 254 cycles then one ready cycle, mem_timeout stays 0.
- Preload stall_count to all-ones (via force) plus one hdu_stall → stall_count unchanged; reset_n low mid-DRAIN → state RUN, counters 0, halted=0.
